// File: rtl/mode_counter_pkg.sv
// Shared types and step rules for the mode-programmable counter bank.
//   MAX_WIDTH   : widest counter supported; the step helpers work at this width
//   mode_t      : counting mode selected by LOAD
//   cmd_t       : command codes on the shared command port (codes 6/7 act as NOP)
//   state_t     : per-channel run state
//   next_count  : count after one step (caller truncates to its own width)
//   is_terminal : one step from this count ends the run (non-wrapping modes only)
//   is_wrap     : one step from this count produces a wrap event
package mode_counter_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      MODE_UP        = 2'd0,
      MODE_DOWN      = 2'd1,
      MODE_UP_WRAP   = 2'd2,
      MODE_DOWN_WRAP = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_LOAD  = 3'd1,
      CMD_LIMIT = 3'd2,
      CMD_START = 3'd3,
      CMD_STOP  = 3'd4,
      CMD_CLEAR = 3'd5
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [MAX_WIDTH-1:0] CNT_ONE = MAX_WIDTH'(1);

   // Increments are only taken below limit and decrements only above zero,
   // so the result never leaves [0, limit] or [0, all-ones].
   function automatic logic [MAX_WIDTH-1:0] next_count(
      input mode_t                m,
      input logic [MAX_WIDTH-1:0] cnt,
      input logic [MAX_WIDTH-1:0] lim
   );
      logic [MAX_WIDTH-1:0] r;
      r = cnt;
      case (m)
         MODE_UP:        r = (cnt >= lim) ? cnt : cnt + CNT_ONE;
         MODE_DOWN:      r = (cnt == '0)  ? cnt : cnt - CNT_ONE;
         MODE_UP_WRAP:   r = (cnt >= lim) ? '0  : cnt + CNT_ONE;
         MODE_DOWN_WRAP: r = (cnt == '0)  ? lim : cnt - CNT_ONE;
         default:        r = cnt;
      endcase
      return r;
   endfunction

   // True when a step either finds the channel already at its end point or
   // lands exactly on it.
   function automatic logic is_terminal(
      input mode_t                m,
      input logic [MAX_WIDTH-1:0] cnt,
      input logic [MAX_WIDTH-1:0] lim
   );
      logic t;
      t = 1'b0;
      case (m)
         MODE_UP:   t = (cnt >= lim) || ((cnt + CNT_ONE) == lim);
         MODE_DOWN: t = (cnt <= CNT_ONE);
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

   function automatic logic is_wrap(
      input mode_t                m,
      input logic [MAX_WIDTH-1:0] cnt,
      input logic [MAX_WIDTH-1:0] lim
   );
      logic w;
      w = 1'b0;
      case (m)
         MODE_UP_WRAP:   w = (cnt >= lim);
         MODE_DOWN_WRAP: w = (cnt == '0);
         default:        w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mode_counter_channel.sv
// One counter channel: IDLE/RUN/DONE FSM plus count, limit and mode registers.
// Optional wrap counter enabled by macro MODE_COUNTER_WRAP_CNT_EN.
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : step enable while in RUN
//   cmd_en     : an accepted, effective (non-NOP) command targets this channel
//   cmd        : command code
//   cmd_mode   : mode for LOAD
//   cmd_data   : value for LOAD / LIMIT
//   count      : registered count
//   busy, done : channel in RUN / DONE
//   wrap       : one-cycle wrap pulse
//   wrap_cnt   : saturating wrap count (zero when the macro is undefined)
module mode_counter_channel
   import mode_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cmd_en,
   input  logic [2:0]       cmd,
   input  logic [1:0]       cmd_mode,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [7:0]       wrap_cnt
);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic [WIDTH-1:0]     limit_q, limit_d;
   mode_t                mode_q, mode_d;
   logic                 wrap_q, wrap_d;
   cmd_t                 op;
   logic                 step;
   logic [MAX_WIDTH-1:0] cnt_ext, lim_ext;

   assign op      = cmd_t'(cmd);
   assign cnt_ext = MAX_WIDTH'(count_q);
   assign lim_ext = MAX_WIDTH'(limit_q);
   // A command on this channel pre-empts the step in the same cycle.
   assign step    = (state_q == ST_RUN) && tick && !cmd_en;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (cmd_en) begin
         case (op)
            CMD_START: if (state_q == ST_IDLE) state_d = ST_RUN;
            CMD_STOP:  if (state_q == ST_RUN)  state_d = ST_IDLE;
            CMD_CLEAR: state_d = ST_IDLE;
            default:   state_d = state_q;
         endcase
      end else if (step && is_terminal(mode_q, cnt_ext, lim_ext)) begin
         state_d = ST_DONE;
      end
   end

   // Output decode
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   // Datapath next values
   always_comb begin
      count_d = count_q;
      limit_d = limit_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;
      if (cmd_en) begin
         case (op)
            CMD_LOAD: begin
               count_d = cmd_data;
               mode_d  = mode_t'(cmd_mode);
            end
            CMD_LIMIT: limit_d = cmd_data;
            CMD_CLEAR: count_d = '0;
            default: ;
         endcase
      end else if (step) begin
         count_d = WIDTH'(next_count(mode_q, cnt_ext, lim_ext));
         wrap_d  = is_wrap(mode_q, cnt_ext, lim_ext);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         limit_q <= '1;
         mode_q  <= MODE_UP;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         limit_q <= limit_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

`ifdef MODE_COUNTER_WRAP_CNT_EN
   logic [7:0] wrap_cnt_q;

   // Advances on the same edge that raises the wrap pulse, saturating at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              wrap_cnt_q <= '0;
      else if (cmd_en && op == CMD_CLEAR)   wrap_cnt_q <= '0;
      else if (wrap_d && wrap_cnt_q != '1)  wrap_cnt_q <= wrap_cnt_q + 8'd1;
   end

   assign wrap_cnt = wrap_cnt_q;
`else
   assign wrap_cnt = '0;
`endif

endmodule

// File: rtl/mode_counter_array.sv
// Bank of N_CH mode-programmable counters sharing one valid/ready command port.
// Optional per-channel wrap counters enabled by macro MODE_COUNTER_WRAP_CNT_EN.
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_tick               : global step enable
//   i_cmd_valid          : command valid; o_cmd_ready : command ready
//   i_cmd/i_cmd_ch       : command code and target channel
//   i_cmd_mode/i_cmd_data: LOAD mode, LOAD/LIMIT value
//   o_count              : packed counts, channel k at [k*WIDTH +: WIDTH]
//   o_busy/o_done/o_wrap : per-channel RUN, DONE, wrap pulse
//   o_wrap_cnt           : packed 8-bit wrap counts
module mode_counter_array
   import mode_counter_pkg::*;
#(
   parameter  int unsigned N_CH  = 4,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_tick,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [2:0]            i_cmd,
   input  logic [CH_W-1:0]       i_cmd_ch,
   input  logic [1:0]            i_cmd_mode,
   input  logic [WIDTH-1:0]      i_cmd_data,
   output logic [N_CH*WIDTH-1:0] o_count,
   output logic [N_CH-1:0]       o_busy,
   output logic [N_CH-1:0]       o_done,
   output logic [N_CH-1:0]       o_wrap,
   output logic [N_CH*8-1:0]     o_wrap_cnt
);

   cmd_t            op;
   logic            sel_done;
   logic            accept;
   logic            is_op;
   logic [N_CH-1:0] cmd_en;

   assign op = cmd_t'(i_cmd);

   // Compare against each channel index rather than indexing o_done, so an
   // out-of-range channel simply selects nothing.
   always_comb begin
      sel_done = 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (i_cmd_ch == CH_W'(k) && o_done[k]) sel_done = 1'b1;
      end
   end

   assign o_cmd_ready = !(sel_done && op != CMD_CLEAR);
   assign accept      = i_cmd_valid && o_cmd_ready;
   assign is_op       = op inside {CMD_LOAD, CMD_LIMIT, CMD_START, CMD_STOP, CMD_CLEAR};

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign cmd_en[g] = accept && is_op && (i_cmd_ch == CH_W'(g));

      mode_counter_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk      (i_clk),
         .rst      (i_rst),
         .tick     (i_tick),
         .cmd_en   (cmd_en[g]),
         .cmd      (i_cmd),
         .cmd_mode (i_cmd_mode),
         .cmd_data (i_cmd_data),
         .count    (o_count[g*WIDTH +: WIDTH]),
         .busy     (o_busy[g]),
         .done     (o_done[g]),
         .wrap     (o_wrap[g]),
         .wrap_cnt (o_wrap_cnt[g*8 +: 8])
      );
   end

endmodule

// File: tb/tb_mode_counter_array.sv
// Self-checking bench for mode_counter_array: directed scenarios with literal
// expectations, then randomized commands checked every cycle against a
// behavioural model. Honours MODE_COUNTER_WRAP_CNT_EN.
module tb_mode_counter_array;

   localparam int N_CH  = 4;
   localparam int WIDTH = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef MODE_COUNTER_WRAP_CNT_EN
   localparam bit WC_EN = 1'b1;
`else
   localparam bit WC_EN = 1'b0;
`endif

   logic                  i_clk = 1'b0;
   logic                  i_rst = 1'b0;
   logic                  i_tick = 1'b0;
   logic                  i_cmd_valid = 1'b0;
   logic                  o_cmd_ready;
   logic [2:0]            i_cmd = '0;
   logic [1:0]            i_cmd_ch = '0;
   logic [1:0]            i_cmd_mode = '0;
   logic [WIDTH-1:0]      i_cmd_data = '0;
   logic [N_CH*WIDTH-1:0] o_count;
   logic [N_CH-1:0]       o_busy, o_done, o_wrap;
   logic [N_CH*8-1:0]     o_wrap_cnt;

   mode_counter_array #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_tick      (i_tick),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd       (i_cmd),
      .i_cmd_ch    (i_cmd_ch),
      .i_cmd_mode  (i_cmd_mode),
      .i_cmd_data  (i_cmd_data),
      .o_count     (o_count),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_wrap      (o_wrap),
      .o_wrap_cnt  (o_wrap_cnt)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int k);
      return 32'(o_count[k*WIDTH +: WIDTH]);
   endfunction

   function automatic logic [31:0] wc_of(input int k);
      return 32'(o_wrap_cnt[k*8 +: 8]);
   endfunction

   // ---------------- behavioural model ----------------
   // state: 0 idle, 1 running, 2 finished
   int m_cnt [N_CH];
   int m_lim [N_CH];
   int m_mode[N_CH];
   int m_st  [N_CH];
   int m_wrap[N_CH];
   int m_wc  [N_CH];

   function automatic bit model_ready();
      return !(m_st[i_cmd_ch] == 2 && i_cmd != 3'd5);
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_CH; k++) begin
            m_cnt[k] = 0; m_lim[k] = MAXV; m_mode[k] = 0;
            m_st[k] = 0;  m_wrap[k] = 0;   m_wc[k] = 0;
         end
      end else begin
         bit acc;
         int c;
         acc = i_cmd_valid && model_ready();
         for (int k = 0; k < N_CH; k++) begin
            m_wrap[k] = 0;
            if (acc && int'(i_cmd_ch) == k && i_cmd >= 3'd1 && i_cmd <= 3'd5) begin
               case (i_cmd)
                  3'd1: begin m_cnt[k] = int'(i_cmd_data); m_mode[k] = int'(i_cmd_mode); end
                  3'd2: m_lim[k] = int'(i_cmd_data);
                  3'd3: if (m_st[k] == 0) m_st[k] = 1;
                  3'd4: if (m_st[k] == 1) m_st[k] = 0;
                  default: begin m_st[k] = 0; m_cnt[k] = 0; m_wc[k] = 0; end
               endcase
            end else if (m_st[k] == 1 && i_tick) begin
               c = m_cnt[k];
               case (m_mode[k])
                  0: if (c >= m_lim[k]) m_st[k] = 2;
                     else begin c = c + 1; if (c == m_lim[k]) m_st[k] = 2; end
                  1: if (c == 0) m_st[k] = 2;
                     else begin c = c - 1; if (c == 0) m_st[k] = 2; end
                  2: if (c >= m_lim[k]) begin c = 0; m_wrap[k] = 1; end
                     else c = c + 1;
                  default: if (c == 0) begin c = m_lim[k]; m_wrap[k] = 1; end
                     else c = c - 1;
               endcase
               m_cnt[k] = c;
               if (m_wrap[k] == 1 && m_wc[k] < 255) m_wc[k] = m_wc[k] + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("ready", 0, 32'(o_cmd_ready), 32'(model_ready()));
         for (int k = 0; k < N_CH; k++) begin
            check("count", k, cnt_of(k), 32'(m_cnt[k]));
            check("busy",  k, 32'(o_busy[k]), 32'(m_st[k] == 1));
            check("done",  k, 32'(o_done[k]), 32'(m_st[k] == 2));
            check("wrap",  k, 32'(o_wrap[k]), 32'(m_wrap[k]));
            check("wrap_cnt", k, wc_of(k), WC_EN ? 32'(m_wc[k]) : 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input int c, input int ch, input int md, input int d);
      i_cmd_valid = 1'b1;
      i_cmd       = 3'(c);
      i_cmd_ch    = 2'(ch);
      i_cmd_mode  = 2'(md);
      i_cmd_data  = WIDTH'(d);
      cyc();
      i_cmd_valid = 1'b0;
      i_cmd       = 3'd0;
   endtask

   initial begin
      // 1: reset held three cycles
      #2 i_rst = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) cyc();
      i_rst = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         check("rst_count", k, cnt_of(k), 0);
         check("rst_busy",  k, 32'(o_busy[k]), 0);
         check("rst_done",  k, 32'(o_done[k]), 0);
      end
      check("rst_ready", 0, 32'(o_cmd_ready), 1);

      // 2: ch0 UP to limit 5
      i_tick = 1'b1;
      send(2, 0, 0, 5);
      send(1, 0, 0, 0);
      send(3, 0, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         check("up_count", i, cnt_of(0), 32'(i));
      end
      check("up_done", 0, 32'(o_done[0]), 1);
      check("up_busy", 0, 32'(o_busy[0]), 0);

      // 3: ch1 UP_WRAP limit 3
      send(2, 1, 0, 3);
      send(1, 1, 2, 0);
      send(3, 1, 0, 0);
      begin
         int exp_c[5] = '{1, 2, 3, 0, 1};
         int exp_w[5] = '{0, 0, 0, 1, 0};
         for (int i = 0; i < 5; i++) begin
            cyc();
            check("wrap_count", i, cnt_of(1), 32'(exp_c[i]));
            check("wrap_pulse", i, 32'(o_wrap[1]), 32'(exp_w[i]));
            if (i == 3) check("wrap_cnt1", i, wc_of(1), WC_EN ? 32'd1 : 32'd0);
         end
      end

      // 4: refused LOAD on a finished channel, then CLEAR
      i_cmd_valid = 1'b1; i_cmd = 3'd1; i_cmd_ch = 2'd0; i_cmd_data = 8'd7;
      #1 check("done_refuse", 0, 32'(o_cmd_ready), 0);
      cyc();
      i_cmd = 3'd5;
      #1 check("clear_ready", 0, 32'(o_cmd_ready), 1);
      cyc();
      i_cmd_valid = 1'b0; i_cmd = 3'd0;
      check("clear_count", 0, cnt_of(0), 0);
      check("clear_done",  0, 32'(o_done[0]), 0);
      check("clear_busy",  0, 32'(o_busy[0]), 0);

      // 5: command beats step on the same channel
      i_tick = 1'b0;
      send(1, 2, 1, 4);
      send(3, 2, 0, 0);
      i_tick = 1'b1;
      send(1, 2, 1, 9);
      check("cmd_wins", 2, cnt_of(2), 9);
      cyc();
      check("down_after_load", 2, cnt_of(2), 8);

      // 6: reset mid-run, then saturating wrap counter
      i_tick = 1'b0;
      send(2, 3, 0, 10);
      send(1, 3, 0, 0);
      send(3, 3, 0, 0);
      i_tick = 1'b1;
      cyc();
      cyc();
      check("pre_rst_count", 3, cnt_of(3), 2);
      i_rst = 1'b1;
      #1;
      check("async_rst_count", 3, cnt_of(3), 0);
      check("async_rst_busy",  3, 32'(o_busy[3]), 0);
      cyc();
      i_rst = 1'b0;
      i_tick = 1'b0;
      send(2, 3, 0, 0);
      send(1, 3, 2, 0);
      send(3, 3, 0, 0);
      i_tick = 1'b1;
      repeat (260) cyc();
      check("wrap_sat", 3, wc_of(3), WC_EN ? 32'd255 : 32'd0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         i_tick      = ($urandom_range(0, 3) != 0);
         i_cmd_valid = 1'($urandom_range(0, 1));
         i_cmd       = 3'($urandom_range(0, 7));
         i_cmd_ch    = 2'($urandom_range(0, N_CH - 1));
         i_cmd_mode  = 2'($urandom_range(0, 3));
         i_cmd_data  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, MAXV))
                                                  : WIDTH'($urandom_range(0, 6));
         if ($urandom_range(0, 599) == 0) begin
            i_rst = 1'b1;
            cyc();
            i_rst = 1'b0;
         end else begin
            cyc();
         end
      end
      i_cmd_valid = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
